// File: rtl/floo_wormhole_arbiter_if.sv
// Handshake bundle for the wormhole output-port arbiter:
// NumInp competing flit inputs on one side, one output link on the other.
interface floo_wormhole_arbiter_if #(
    parameter int unsigned NumInp    = 5,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned IdxWidth  = $clog2(NumInp)
);
    logic [NumInp-1:0]                valid_i;
    logic [NumInp-1:0]                ready_o;
    logic [NumInp-1:0][DataWidth-1:0] data_i;
    logic [NumInp-1:0]                last_i;
    logic                             valid_o;
    logic                             ready_i;
    logic [DataWidth-1:0]             data_o;
    logic                             last_o;
    logic [IdxWidth-1:0]              sel_o;
    logic                             locked_o;

    modport master (
        output valid_i, data_i, last_i, ready_i,
        input  ready_o, valid_o, data_o, last_o, sel_o, locked_o
    );

    modport slave (
        input  valid_i, data_i, last_i, ready_i,
        output ready_o, valid_o, data_o, last_o, sel_o, locked_o
    );
endinterface

// File: rtl/floo_wormhole_arbiter.sv
// Round-robin wormhole arbiter for one router output link.
// Zero-cycle flit path; a grant is held until the packet's last flit.
module floo_wormhole_arbiter #(
    parameter int unsigned NumInp    = 5,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned IdxWidth  = $clog2(NumInp)
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    floo_wormhole_arbiter_if.slave arb
);

    typedef enum logic [1:0] {IDLE, HOLD, LOCKED} state_e;

    localparam logic [IdxWidth:0] NumInpW = (IdxWidth+1)'(NumInp);

    state_e              state;
    logic [IdxWidth-1:0] rr_ptr;
    logic [IdxWidth-1:0] gnt_idx;
    logic [IdxWidth-1:0] cand;
    logic [IdxWidth-1:0] sel;
    logic [IdxWidth:0]   sum;
    logic [IdxWidth-1:0] idx;
    logic                valid;
    logic                hs;
    logic                last;

    function automatic logic [IdxWidth-1:0] wrap_inc(input logic [IdxWidth-1:0] i);
        return (i == IdxWidth'(NumInp - 1)) ? '0 : i + 1'b1;
    endfunction

    // Scan backwards so the input nearest rr_ptr wins.
    always_comb begin
        cand = '0;
        sum  = '0;
        idx  = '0;
        for (int k = NumInp - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (IdxWidth+1)'(k);
            if (sum >= NumInpW) sum = sum - NumInpW;
            idx = sum[IdxWidth-1:0];
            if (arb.valid_i[idx]) cand = idx;
        end
    end

    assign sel   = (state == IDLE) ? cand : gnt_idx;
    assign valid = (state == IDLE) ? |arb.valid_i : arb.valid_i[sel];
    assign hs    = valid & arb.ready_i;
    assign last  = arb.last_i[sel];

    assign arb.valid_o  = valid;
    assign arb.sel_o    = sel;
    assign arb.data_o   = valid ? arb.data_i[sel] : '0;
    assign arb.last_o   = valid & last;
    assign arb.ready_o  = hs ? (NumInp'(1) << sel) : '0;
    assign arb.locked_o = (state == LOCKED);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            gnt_idx <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (hs && last) begin
                        rr_ptr <= wrap_inc(sel);
                    end else if (hs) begin
                        state   <= LOCKED;
                        gnt_idx <= sel;
                    end else if (valid) begin
                        state   <= HOLD;
                        gnt_idx <= sel;
                    end
                end
                HOLD, LOCKED: begin
                    if (hs && last) begin
                        state  <= IDLE;
                        rr_ptr <= wrap_inc(gnt_idx);
                    end else if (hs) begin
                        state <= LOCKED;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A raised valid must be held until its handshake.
    for (genvar i = 0; i < NumInp; i++) begin : g_stable
        a_valid_stable: assert property (
            @(posedge clk_i) disable iff (!rst_ni)
            arb.valid_i[i] && !arb.ready_o[i] |=> arb.valid_i[i]
        );
    end

endmodule

// File: tb/tb_floo_wormhole_arbiter.sv
// Randomized bench for floo_wormhole_arbiter against a packet-level
// ownership model, with directed round-robin, lock, stall and reset cases.
module tb_floo_wormhole_arbiter;

    localparam int N  = 5;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    floo_wormhole_arbiter_if #(.NumInp(N), .DataWidth(DW)) bus ();

    floo_wormhole_arbiter #(.NumInp(N), .DataWidth(DW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .arb    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus: per-input valid, flits left in packet, current payload.
    bit          v   [N];
    int          rem [N];
    logic [63:0] d   [N];
    bit          rdy;
    int          pv, pkeep, pr, maxlen;

    // Model: owner of the link (-1 if free), round-robin start, flits sent.
    int owner, ptr, sent;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int cand();
        if (owner >= 0) return owner;
        for (int k = 0; k < N; k++)
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic present();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            bus.valid_i[i] = v[i];
            bus.last_i[i]  = (rem[i] == 1);
            bus.data_i[i]  = d[i];
        end
        bus.ready_i = rdy;
        #1;
    endtask

    task automatic model_reset();
        owner = -1;
        ptr   = 0;
        sent  = 0;
        for (int i = 0; i < N; i++) begin
            v[i]   = 1'b0;
            rem[i] = 0;
            d[i]   = '0;
        end
    endtask

    // Check the current cycle against the model, then advance model and stimulus.
    task automatic advance();
        int          s;
        bit          ev;
        logic [63:0] e_sel, e_dat, e_rdy;
        s     = cand();
        ev    = (s >= 0) && v[s];
        e_sel = (s < 0) ? 64'd0 : 64'(s);
        e_dat = ev ? d[s] : 64'd0;
        e_rdy = (ev && rdy) ? (64'd1 << s) : 64'd0;
        chk("valid_o", 64'(bus.valid_o), 64'(ev));
        chk("sel_o", 64'(bus.sel_o), e_sel);
        chk("data_o", bus.data_o, e_dat);
        chk("last_o", 64'(bus.last_o), 64'(ev && rem[s] == 1));
        chk("ready_o", 64'(bus.ready_o), e_rdy);
        chk("locked_o", 64'(bus.locked_o), 64'(owner >= 0 && sent > 0));
        if (ev && rdy) begin
            if (rem[s] == 1) begin
                owner = -1;
                ptr   = (s + 1) % N;
                sent  = 0;
            end else begin
                owner = s;
                sent++;
            end
            rem[s]--;
            v[s] = 1'b0;
        end else if (ev) begin
            owner = s;
        end
        for (int i = 0; i < N; i++) begin
            if (!v[i] && $urandom_range(99) < ((rem[i] > 0) ? pkeep : pv)) begin
                if (rem[i] == 0) rem[i] = $urandom_range(maxlen, 1);
                d[i] = {$urandom, $urandom};
                v[i] = 1'b1;
            end
        end
        rdy = ($urandom_range(99) < pr);
    endtask

    function automatic bit any_v();
        for (int i = 0; i < N; i++) if (v[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain();
        int guard;
        pv = 0; pkeep = 100; pr = 100; rdy = 1'b1;
        guard = 0;
        while ((any_v() || owner >= 0) && guard < 200) begin
            present();
            advance();
            guard++;
        end
        chk("drain_timeout", 64'(guard < 200), 64'd1);
    endtask

    task automatic raise(input int i, input int len);
        v[i]   = 1'b1;
        rem[i] = len;
        d[i]   = {$urandom, $urandom};
    endtask

    logic [63:0] held;

    initial begin
        model_reset();
        rdy = 1'b0; pv = 0; pkeep = 0; pr = 0; maxlen = 1;
        present();
        repeat (2) @(negedge clk);
        #1;
        advance();
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin over single-flit packets.
        pv = 100; pkeep = 100; pr = 100; maxlen = 1; rdy = 1'b1;
        for (int i = 0; i < N; i++) raise(i, 1);
        for (int k = 0; k < 6; k++) begin
            present();
            chk("rr_sel", 64'(bus.sel_o), 64'(k % N));
            chk("rr_lock", 64'(bus.locked_o), 64'd0);
            advance();
        end
        drain();

        // Wormhole lock: input 2 sends 4 flits while input 0 waits.
        pv = 0; pkeep = 100; pr = 100; rdy = 1'b1;
        raise(0, 1);
        raise(2, 4);
        for (int k = 0; k < 5; k++) begin
            present();
            chk("lock_sel", 64'(bus.sel_o), (k < 4) ? 64'd2 : 64'd0);
            if (k < 4) chk("lock_rdy0", 64'(bus.ready_o[0]), 64'd0);
            if (k > 0 && k < 4) chk("lock_on", 64'(bus.locked_o), 64'd1);
            advance();
            rdy = 1'b1;
        end

        // Backpressure hold with the pointer at 3.
        raise(2, 1);
        present(); advance();
        raise(1, 1);
        raise(3, 1);
        rdy = 1'b0;
        held = d[3];
        for (int k = 0; k < 4; k++) begin
            present();
            chk("bp_sel", 64'(bus.sel_o), 64'd3);
            chk("bp_data", bus.data_o, held);
            chk("bp_rdy", 64'(bus.ready_o), (k == 3) ? 64'd8 : 64'd0);
            advance();
            rdy = (k >= 2);
        end
        present();
        chk("bp_next", 64'(bus.sel_o), 64'd1);
        advance();

        // Wrap-around after input 4 completes.
        rdy = 1'b1;
        raise(4, 1);
        present(); advance();
        raise(0, 1);
        raise(4, 1);
        present();
        chk("wrap_sel", 64'(bus.sel_o), 64'd0);
        advance();
        drain();

        // Mid-packet stall on the locked input.
        pkeep = 0; pv = 0; rdy = 1'b1;
        raise(1, 3);
        present(); advance();
        raise(3, 1);
        rdy = 1'b1;
        for (int k = 0; k < 2; k++) begin
            present();
            chk("stall_valid", 64'(bus.valid_o), 64'd0);
            chk("stall_rdy", 64'(bus.ready_o), 64'd0);
            chk("stall_lock", 64'(bus.locked_o), 64'd1);
            advance();
            rdy = 1'b1;
        end
        pkeep = 100;
        v[1] = 1'b1;
        drain();

        // Randomized traffic.
        pv = 50; pkeep = 70; pr = 70; maxlen = 4;
        for (int c = 0; c < 3000; c++) begin
            present();
            advance();
        end
        drain();

        // Reset during flit 2 of a 3-flit packet from input 3.
        pv = 0; pkeep = 100; rdy = 1'b1;
        raise(3, 3);
        present(); advance();
        present();
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < N; i++) bus.valid_i[i] = 1'b0;
        #1;
        chk("rst_valid", 64'(bus.valid_o), 64'd0);
        chk("rst_ready", 64'(bus.ready_o), 64'd0);
        chk("rst_last", 64'(bus.last_o), 64'd0);
        chk("rst_sel", 64'(bus.sel_o), 64'd0);
        chk("rst_data", bus.data_o, 64'd0);
        chk("rst_lock", 64'(bus.locked_o), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rdy = 1'b1;
        raise(2, 1);
        raise(3, 1);
        present();
        chk("post_rst_sel", 64'(bus.sel_o), 64'd2);
        advance();
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/floo_wormhole_arbiter.md
# floo_wormhole_arbiter

Wormhole output-port arbiter for the FlooNoC router. It shares one router output link between `NumInp` input ports, which are by default the five `route_direction_e` directions North, East, South, West and Eject. It grants packets in round-robin order and holds a grant for the whole packet until its last flit. It sits after route computation (XY, IdTable or SourceRouting), with one instance per output direction, and has no flit storage.

## Interface
Parameters:
- `NumInp`, default 5: number of competing inputs. Must be 2..8; non-power-of-two values are allowed.
- `DataWidth`, default 64: flit payload width.
- `IdxWidth`, default `$clog2(NumInp)`: width of the selected-input index. Derived; do not override.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `valid_i`  in  NumInp  per-input flit valid.
- `ready_o`  out  NumInp  per-input ready.
- `data_i`  in  NumInp×DataWidth  per-input flit payload.
- `last_i`  in  NumInp  per-input last-flit-of-packet marker.
- `valid_o`  out  1  output flit valid.
- `ready_i`  in  1  output link ready.
- `data_o`  out  DataWidth  payload of the granted input.
- `last_o`  out  1  last marker of the granted input.
- `sel_o`  out  IdxWidth  index of the granted input.
- `locked_o`  out  1  high while a multi-flit packet holds the link.

## Operation
- State: `state` ∈ {IDLE, HOLD, LOCKED}, `rr_ptr` (IdxWidth bits), `gnt_idx` (IdxWidth bits).
- **IDLE.** Candidate = first input `i` with `valid_i[i]` high, searching `rr_ptr, rr_ptr+1, …` and wrapping modulo NumInp.
  - `valid_o` = any `valid_i`.
  - `sel_o` = candidate.
  - `data_o` and `last_o` are muxed from the candidate.
- **HOLD or LOCKED.** The selection is `gnt_idx` only.
  - `valid_o` = `valid_i[gnt_idx]`.
  - All other inputs see `ready_o` = 0.
- Ready: `ready_o[i] = ready_i & valid_o & (i == sel_o)`.
- Handshake: `hs = valid_o & ready_i`.
- Transitions, evaluated on the selected input:
  - IDLE, `valid_o & !ready_i`: go to HOLD and capture `gnt_idx` = candidate. This freezes the selection so output data stays stable.
  - IDLE or HOLD, `hs & last`: go to IDLE and set `rr_ptr` = (sel+1) mod NumInp.
  - IDLE or HOLD, `hs & !last`: go to LOCKED and set `gnt_idx` = sel.
  - LOCKED, `hs & last`: go to IDLE and set `rr_ptr` = (gnt_idx+1) mod NumInp.
  - LOCKED, all other cases: stay in LOCKED.
  - HOLD, no handshake: stay in HOLD.
- Wrap: when sel = NumInp-1, `rr_ptr` becomes 0. The pointer never holds a value ≥ NumInp.
- `locked_o` = (state == LOCKED).
- Upstream rule: once raised, `valid_i[i]` must stay high until its handshake. An SVA assertion checks this, and the arbiter's output is undefined if it is violated.
- Single-flit packets (`last_i` = 1 on the first flit) never enter LOCKED.
- Reset: the reset is asynchronous. It forces IDLE, `rr_ptr` = 0 and `gnt_idx` = 0. A packet in flight at reset is abandoned, and after reset arbitration restarts from input 0.

## Timing
- Zero-cycle datapath. `valid_o`, `data_o`, `last_o`, `sel_o` and `ready_o` are combinational from `valid_i`, `data_i`, `last_i`, `ready_i` and the registered state. No registers sit on the flit path.
- Throughput: one flit per cycle while `ready_i` is high.
- Back-to-back packets from different inputs: there is no bubble between them. The cycle after a `last` handshake arbitrates with the new `rr_ptr`.
- Output values while the arbiter sits in IDLE:
  - With all `valid_i` = 0: `valid_o`=0, `ready_o`=0, `last_o`=0, `sel_o`=0, `data_o`=0, `locked_o`=0.
  - After reset with `valid_i` = 0, the outputs take exactly these values.
- State updates on the `clk_i` rising edge only. Reset acts asynchronously on assertion and is released synchronously by the surrounding reset synchroniser.

## Test plan
- **Round-robin, single flits.** NumInp=5, all `valid_i`=1, all `last_i`=1, `ready_i`=1. Required: `sel_o` sequence 0,1,2,3,4,0 on consecutive cycles, with `locked_o` held at 0.
- **Wormhole lock.** Input 2 sends a 4-flit packet (last on flit 4) while input 0 is continuously valid. Required: `sel_o`=2 for 4 cycles with `locked_o`=1 during flits 2–4; `ready_o[0]`=0 throughout; then `sel_o`=0.
- **Backpressure hold.** Inputs 1 and 3 are valid, `rr_ptr`=3, `ready_i`=0 for 3 cycles, then 1. Required: `sel_o`=3 and `data_o` stable during the stall; input 3's handshake happens in cycle 4; input 1 is served next.
- **Wrap-around.** NumInp=5; input 4 is granted and completes. Required: `rr_ptr`=0, and with inputs 0 and 4 both valid the next grant is 0.
- **Mid-packet stall.** In LOCKED, `valid_i[gnt_idx]` drops for 2 cycles while other inputs are valid. Required: `valid_o`=0, no other grant, and `locked_o` stays 1.
- **Reset mid-packet.** Assert `rst_ni`=0 during flit 2 of a 3-flit packet from input 3. Required: all outputs return immediately to their idle values; after release with inputs 2 and 3 valid, the first grant is `sel_o`=2.
